keccak_pad_stream: RTL and testbench

- Streaming multi-block Keccak/SHA-3 padder.
- Accepts message chunks of a parametrised width over a valid/ready handshake and packs them into rate-sized blocks.
- Applies pad10*1 with a parametrised domain-separation byte and emits one block per handshake to the permutation/absorb stage.
- Supports messages of any length (multi-block), empty messages, and exact-fill messages. Serves SHAKE128/256 and SHA3-* by parameter.

---
 rtl/keccak_pad_stream.sv | 209 ++++++++++++++++++++
 tb/tb_keccak_pad_stream.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_pad_stream.sv
// keccak_pad_stream: streaming Keccak/SHA-3 pad10*1 padder.
// Packs IN_W-bit chunks (MSB-first within each byte) into RATE_BYTES-byte
// blocks and emits one block per block_valid/block_ready handshake. The
// final block of every message carries the DOMAIN byte and the closing 0x80.
// Optional build macro: KECCAK_PAD_STATS_EN adds per-message statistics
// outputs (stat_msg_bytes, stat_blocks).
module keccak_pad_stream #(
  parameter int          RATE_BYTES = 136,
  parameter int          IN_W       = 8,
  parameter logic [7:0]  DOMAIN     = 8'h1F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_last,
  input  logic                    flush,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic [RATE_BYTES*8-1:0] block,
  output logic                    block_last
`ifdef KECCAK_PAD_STATS_EN
  ,
  output logic [31:0]             stat_msg_bytes,
  output logic [15:0]             stat_blocks
`endif
);

  localparam int CPB = 8 / IN_W;
  localparam int BCW = $clog2(RATE_BYTES + 1);
  localparam int CCW = (CPB > 1) ? $clog2(CPB) : 1;

  // Block sent after an exact-fill data block: only the padding bits.
  localparam logic [RATE_BYTES*8-1:0] PAD_ONLY =
    ({8'h80, {(RATE_BYTES*8-8){1'b0}}}) | (RATE_BYTES*8)'(DOMAIN);

  typedef enum logic [1:0] {
    FILL,
    EMIT_DATA,
    EMIT_FINAL
  } state_t;

  state_t           state;
  logic [7:0]       acc;
  logic [CCW-1:0]   chunk_cnt;
  logic [BCW-1:0]   byte_cnt;
  logic             pad_pending;

  logic                    beat;
  logic                    is_last;
  logic                    has_data;
  logic [7:0]              acc_n;
  int                      nchunks;
  logic                    full_byte;
  logic                    part_byte;
  logic                    wr_en;
  logic [7:0]              wr_byte;
  int                      wr_i;
  int                      n_after;
  logic                    pad_en;
  logic [RATE_BYTES*8-1:0] blk_fill;

  // Decode the current input beat: accumulator update, byte write and padding.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    beat     = in_valid && in_ready && (state == FILL);
    is_last  = in_last || flush;
    // in_last wins over flush: the chunk is kept whenever in_last is set.
    has_data = in_last || !flush;
    acc_n    = acc;
    if (has_data) begin
      acc_n = 8'(acc << IN_W) | 8'(in_data);
    end
    nchunks   = int'(chunk_cnt) + (has_data ? 1 : 0);
    full_byte = (nchunks == CPB);
    // A final partial byte is left-aligned with zero fill below it.
    part_byte = is_last && (nchunks != 0) && !full_byte;
    wr_en     = beat && (full_byte || part_byte);
    wr_byte   = full_byte ? acc_n : 8'(acc_n << ((CPB - nchunks) * IN_W));
    wr_i      = int'(byte_cnt);
    n_after   = int'(byte_cnt) + (wr_en ? 1 : 0);
    // Exact fill (n_after == RATE_BYTES) defers padding to a pad-only block.
    pad_en    = beat && is_last && (n_after < RATE_BYTES);
  end

  // Per-byte next block content: new data byte OR'd with any padding bits.
  // Bytes at and beyond the write position are still zero, so OR merges
  // DOMAIN and 0x80 correctly, including the DOMAIN|0x80 case in the last byte.
  for (genvar k = 0; k < RATE_BYTES; k++) begin : g_byte
    assign blk_fill[8*k +: 8] =
        ((wr_en && (wr_i == k)) ? wr_byte : block[8*k +: 8])
      | ((pad_en && (n_after == k)) ? DOMAIN : 8'h00)
      | ((pad_en && (k == RATE_BYTES - 1)) ? 8'h80 : 8'h00);
  end

  // Padder FSM with registered handshake outputs and block register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FILL;
      in_ready    <= 1'b0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      // NOTE: the block is a flop bank seen directly by the consumer, so it is reset too.
      block       <= '0;
      acc         <= '0;
      chunk_cnt   <= '0;
      byte_cnt    <= '0;
      pad_pending <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (beat) begin
            block    <= blk_fill;
            byte_cnt <= BCW'(n_after);
            if (full_byte || is_last) begin
              acc       <= '0;
              chunk_cnt <= '0;
            end else begin
              acc       <= acc_n;
              chunk_cnt <= CCW'(nchunks);
            end
            if (is_last && (n_after < RATE_BYTES)) begin
              state       <= EMIT_FINAL;
              in_ready    <= 1'b0;
              block_valid <= 1'b1;
              block_last  <= 1'b1;
            end else if (n_after == RATE_BYTES) begin
              state       <= EMIT_DATA;
              in_ready    <= 1'b0;
              block_valid <= 1'b1;
              block_last  <= 1'b0;
              pad_pending <= is_last;
            end
          end
        end
        EMIT_DATA: begin
          if (block_ready) begin
            byte_cnt  <= '0;
            chunk_cnt <= '0;
            acc       <= '0;
            if (pad_pending) begin
              block      <= PAD_ONLY;
              block_last <= 1'b1;
              state      <= EMIT_FINAL;
            end else begin
              block       <= '0;
              block_valid <= 1'b0;
              in_ready    <= 1'b1;
              state       <= FILL;
            end
          end
        end
        EMIT_FINAL: begin
          if (block_ready) begin
            block       <= '0;
            byte_cnt    <= '0;
            chunk_cnt   <= '0;
            acc         <= '0;
            pad_pending <= 1'b0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            in_ready    <= 1'b1;
            state       <= FILL;
          end
        end
        default: begin
          state       <= FILL;
          in_ready    <= 1'b0;
          block_valid <= 1'b0;
          block_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef KECCAK_PAD_STATS_EN
  logic [31:0] run_bytes;
  logic [15:0] run_blocks;

  // Running per-message counts, published on the final-block handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_bytes      <= '0;
      run_blocks     <= '0;
      stat_msg_bytes <= '0;
      stat_blocks    <= '0;
    end else begin
      // Byte writes happen only in FILL and handshakes only in EMIT states.
      if (wr_en) begin
        run_bytes <= run_bytes + 32'd1;
      end
      if (block_valid && block_ready) begin
        if (block_last) begin
          stat_msg_bytes <= run_bytes;
          stat_blocks    <= run_blocks + 16'd1;
          run_bytes      <= '0;
          run_blocks     <= '0;
        end else begin
          run_blocks <= run_blocks + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_keccak_pad_stream.sv
// tb_keccak_pad_stream: directed self-checking bench for keccak_pad_stream.
// Four instances share clk/reset: SHAKE256 (136,1F), SHA3 (136,06),
// rate-168 SHA3-style, and a 2-bit-chunk SHAKE256 instance.
module tb_keccak_pad_stream;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       flush = 1'b0;
  logic       block_ready = 1'b0;

  logic          rdy_a, bv_a, bl_a;
  logic [1087:0] blk_a;
  logic          rdy_b, bv_b, bl_b;
  logic [1087:0] blk_b;
  logic          rdy_c, bv_c, bl_c;
  logic [1343:0] blk_c;

  logic          v2 = 1'b0;
  logic [1:0]    d2 = 2'b00;
  logic          l2 = 1'b0;
  logic          f2 = 1'b0;
  logic          rdy_d, bv_d, bl_d;
  logic [1087:0] blk_d;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef KECCAK_PAD_STATS_EN
  logic [31:0] smb_a, smb_b, smb_c, smb_d;
  logic [15:0] sbl_a, sbl_b, sbl_c, sbl_d;
`endif

  always #5 clk = ~clk;

  keccak_pad_stream #(.RATE_BYTES(136), .IN_W(8), .DOMAIN(8'h1F)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .block_valid(bv_a), .block_ready(block_ready), .block(blk_a), .block_last(bl_a)
`ifdef KECCAK_PAD_STATS_EN
    , .stat_msg_bytes(smb_a), .stat_blocks(sbl_a)
`endif
  );

  keccak_pad_stream #(.RATE_BYTES(136), .IN_W(8), .DOMAIN(8'h06)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .block_valid(bv_b), .block_ready(block_ready), .block(blk_b), .block_last(bl_b)
`ifdef KECCAK_PAD_STATS_EN
    , .stat_msg_bytes(smb_b), .stat_blocks(sbl_b)
`endif
  );

  keccak_pad_stream #(.RATE_BYTES(168), .IN_W(8), .DOMAIN(8'h06)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .block_valid(bv_c), .block_ready(block_ready), .block(blk_c), .block_last(bl_c)
`ifdef KECCAK_PAD_STATS_EN
    , .stat_msg_bytes(smb_c), .stat_blocks(sbl_c)
`endif
  );

  keccak_pad_stream #(.RATE_BYTES(136), .IN_W(2), .DOMAIN(8'h1F)) dut_d (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy_d),
    .in_data(d2), .in_last(l2), .flush(f2),
    .block_valid(bv_d), .block_ready(block_ready), .block(blk_d), .block_last(bl_d)
`ifdef KECCAK_PAD_STATS_EN
    , .stat_msg_bytes(smb_d), .stat_blocks(sbl_d)
`endif
  );

  // Place byte v at position k of an expected 136-byte block.
  function automatic logic [1087:0] put136(input logic [1087:0] e, input int k,
                                           input logic [7:0] v);
    return e | ({1080'd0, v} << (8 * k));
  endfunction

  function automatic logic [1343:0] put168(input logic [1343:0] e, input int k,
                                           input logic [7:0] v);
    return e | ({1336'd0, v} << (8 * k));
  endfunction

  function automatic logic [1087:0] exp_abc();
    logic [1087:0] e;
    e = '0;
    e = put136(e, 0, 8'h61);
    e = put136(e, 1, 8'h62);
    e = put136(e, 2, 8'h63);
    e = put136(e, 3, 8'h1F);
    e = put136(e, 135, 8'h80);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    v2 = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  // Present one 8-bit beat to the shared bus and hold it until dut_a takes it.
  task automatic send8(input logic [7:0] d, input logic last, input logic fl);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    flush    = fl;
    while (rdy_a !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send8_timeout: in_ready=%b required 1", rdy_a);
    end else begin
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send2(input logic [1:0] d, input logic last);
    int t;
    t = 0;
    v2 = 1'b1;
    d2 = d;
    l2 = last;
    while (rdy_d !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send2_timeout: in_ready=%b required 1", rdy_d);
    end else begin
      step();
    end
    v2 = 1'b0;
    l2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    n_cmp++;
    if (rdy_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 0", rdy_a);
    end
    n_cmp++;
    if (bv_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_block_valid: got %b want 0", bv_a);
    end
    n_cmp++;
    if (bl_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_block_last: got %b want 0", bl_a);
    end
    n_cmp++;
    if (blk_a !== '0) begin
      n_bad++; $display("FAIL reset_block: got %h want 0", blk_a);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if ({rdy_a, rdy_d, bv_a} !== 3'b110) begin
      n_bad++; $display("FAIL reset_release: rdy_a,rdy_d,bv=%b want 110", {rdy_a, rdy_d, bv_a});
    end
  endtask

  // "abc" with block_ready high; assumes the padder is idle in FILL.
  task automatic run_abc(input string tag);
    block_ready = 1'b1;
    send8(8'h61, 1'b0, 1'b0);
    send8(8'h62, 1'b0, 1'b0);
    n_cmp++;
    if (bv_a !== 1'b0) begin
      n_bad++; $display("FAIL %s_early_valid: got %b want 0", tag, bv_a);
    end
    send8(8'h63, 1'b1, 1'b0);
    n_cmp++;
    if (bv_a !== 1'b1) begin
      n_bad++; $display("FAIL %s_latency: block_valid=%b want 1", tag, bv_a);
    end
    n_cmp++;
    if (blk_a !== exp_abc()) begin
      n_bad++; $display("FAIL %s_block: got %h want %h", tag, blk_a, exp_abc());
    end
    n_cmp++;
    if (bl_a !== 1'b1) begin
      n_bad++; $display("FAIL %s_last: got %b want 1", tag, bl_a);
    end
    step();
    n_cmp++;
    if ({bv_a, rdy_a} !== 2'b01) begin
      n_bad++; $display("FAIL %s_after_hs: valid,ready=%b want 01", tag, {bv_a, rdy_a});
    end
`ifdef KECCAK_PAD_STATS_EN
    n_cmp++;
    if (smb_a !== 32'd3 || sbl_a !== 16'd1) begin
      n_bad++; $display("FAIL %s_stats: bytes=%0d blocks=%0d want 3 1", tag, smb_a, sbl_a);
    end
`endif
  endtask

  task automatic test_abc();
    do_reset();
    run_abc("abc");
  endtask

  task automatic test_fill_minus_one();
    logic [1087:0] e;
    do_reset();
    block_ready = 1'b1;
    e = '0;
    for (int k = 0; k < 135; k++) e = put136(e, k, 8'hA5);
    e = put136(e, 135, 8'h9F);
    for (int k = 0; k < 135; k++) send8(8'hA5, (k == 134), 1'b0);
    n_cmp++;
    if (blk_a !== e || bv_a !== 1'b1) begin
      n_bad++; $display("FAIL fill135_block: valid=%b got %h want %h", bv_a, blk_a, e);
    end
    n_cmp++;
    if (bl_a !== 1'b1) begin
      n_bad++; $display("FAIL fill135_last: got %b want 1", bl_a);
    end
    step();
  endtask

  task automatic test_exact_fill();
    logic [1087:0] e_data, e_pad;
    do_reset();
    block_ready = 1'b1;
    e_data = {136{8'h3C}};
    e_pad  = put136(put136('0, 0, 8'h1F), 135, 8'h80);
    for (int k = 0; k < 136; k++) send8(8'h3C, (k == 135), 1'b0);
    n_cmp++;
    if (blk_a !== e_data || bv_a !== 1'b1) begin
      n_bad++; $display("FAIL exact_data_block: valid=%b got %h want %h", bv_a, blk_a, e_data);
    end
    n_cmp++;
    if (bl_a !== 1'b0) begin
      n_bad++; $display("FAIL exact_data_last: got %b want 0", bl_a);
    end
    step();
    n_cmp++;
    if (blk_a !== e_pad || bv_a !== 1'b1) begin
      n_bad++; $display("FAIL exact_pad_block: valid=%b got %h want %h", bv_a, blk_a, e_pad);
    end
    n_cmp++;
    if ({bl_a, rdy_a} !== 2'b10) begin
      n_bad++; $display("FAIL exact_pad_last_ready: last,ready=%b want 10", {bl_a, rdy_a});
    end
    step();
    n_cmp++;
    if (bv_a !== 1'b0) begin
      n_bad++; $display("FAIL exact_done: block_valid=%b want 0", bv_a);
    end
`ifdef KECCAK_PAD_STATS_EN
    n_cmp++;
    if (smb_a !== 32'd136 || sbl_a !== 16'd2) begin
      n_bad++; $display("FAIL exact_stats: bytes=%0d blocks=%0d want 136 2", smb_a, sbl_a);
    end
`endif
  endtask

  task automatic test_last_and_flush();
    logic [1087:0] e;
    do_reset();
    block_ready = 1'b1;
    e = put136(put136(put136('0, 0, 8'h41), 1, 8'h1F), 135, 8'h80);
    send8(8'h41, 1'b1, 1'b1);
    n_cmp++;
    if (blk_a !== e) begin
      n_bad++; $display("FAIL last_flush_block: got %h want %h", blk_a, e);
    end
    n_cmp++;
    if ({bv_a, bl_a} !== 2'b11) begin
      n_bad++; $display("FAIL last_flush_flags: valid,last=%b want 11", {bv_a, bl_a});
    end
    step();
  endtask

  task automatic test_flush_empty();
    logic [1087:0] e_a, e_b;
    logic [1343:0] e_c;
    do_reset();
    block_ready = 1'b1;
    e_a = put136(put136('0, 0, 8'h1F), 135, 8'h80);
    e_b = put136(put136('0, 0, 8'h06), 135, 8'h80);
    e_c = put168(put168('0, 0, 8'h06), 167, 8'h80);
    send8(8'hEE, 1'b0, 1'b1);
    n_cmp++;
    if (blk_a !== e_a || {bv_a, bl_a} !== 2'b11) begin
      n_bad++; $display("FAIL flush_shake: v,l=%b got %h want %h", {bv_a, bl_a}, blk_a, e_a);
    end
    n_cmp++;
    if (blk_b !== e_b) begin
      n_bad++; $display("FAIL flush_sha3_block: got %h want %h", blk_b, e_b);
    end
    n_cmp++;
    if ({bv_b, bl_b} !== 2'b11) begin
      n_bad++; $display("FAIL flush_sha3_flags: valid,last=%b want 11", {bv_b, bl_b});
    end
    n_cmp++;
    if (blk_c !== e_c) begin
      n_bad++; $display("FAIL flush_r168_block: got %h want %h", blk_c, e_c);
    end
    n_cmp++;
    if ({bv_c, bl_c} !== 2'b11) begin
      n_bad++; $display("FAIL flush_r168_flags: valid,last=%b want 11", {bv_c, bl_c});
    end
    step();
    n_cmp++;
    if ({bv_a, bv_b, bv_c} !== 3'b000) begin
      n_bad++; $display("FAIL flush_done: valids=%b want 000", {bv_a, bv_b, bv_c});
    end
  endtask

  task automatic test_in_w2();
    logic [1087:0] e;
    do_reset();
    block_ready = 1'b1;
    e = put136(put136(put136(put136('0, 0, 8'h6C), 1, 8'hC0), 2, 8'h1F), 135, 8'h80);
    send2(2'd1, 1'b0);
    send2(2'd2, 1'b0);
    send2(2'd3, 1'b0);
    send2(2'd0, 1'b0);
    send2(2'd3, 1'b1);
    n_cmp++;
    if (blk_d !== e) begin
      n_bad++; $display("FAIL inw2_block: got %h want %h", blk_d, e);
    end
    n_cmp++;
    if ({bv_d, bl_d} !== 2'b11) begin
      n_bad++; $display("FAIL inw2_flags: valid,last=%b want 11", {bv_d, bl_d});
    end
    step();
  endtask

  task automatic test_backpressure_reset();
    logic [1087:0] e_data;
    do_reset();
    block_ready = 1'b0;
    e_data = {136{8'h3C}};
    for (int k = 0; k < 136; k++) send8(8'h3C, (k == 135), 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({bv_a, rdy_a, bl_a} !== 3'b100 || blk_a !== e_data) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: v,r,l=%b want 100 block %h want %h",
                 i, {bv_a, rdy_a, bl_a}, blk_a, e_data);
      end
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++;
    if (bv_a !== 1'b0 || blk_a !== '0) begin
      n_bad++; $display("FAIL emit_reset: valid=%b block %h want 0", bv_a, blk_a);
    end
    step();
    block_ready = 1'b1;
    send8(8'h11, 1'b0, 1'b0);
    send8(8'h22, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++;
    if (bv_a !== 1'b0 || blk_a !== '0) begin
      n_bad++; $display("FAIL msg_reset: valid=%b block %h want 0", bv_a, blk_a);
    end
    step();
    run_abc("abc_after_reset");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_fill_minus_one();
    test_exact_fill();
    test_last_and_flush();
    test_flush_empty();
    test_in_w2();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
